// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - word-organised RAM responder with programmable wait states
// Optional misaligned-access fault: define MEM_ALIGN_CHECK_EN.
module memory_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        abort
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        abort_q, abort_d;

    logic [31:0] mem [DEPTH];

    logic                  in_idle;
    logic                  eff_wr;
    logic [1:0]            eff_size;
    logic [31:0]           eff_addr, eff_wdata;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  out_of_range, misaligned, fault;
    logic [31:0]           word, word_sh, rd_val, wr_val, wr_mask;
    logic                  mem_we;

    // With no wait states the response is formed on the accepting edge, so the
    // live bus is used while idle and the latched request afterwards.
    always_comb begin
        in_idle      = (state_q == S_IDLE);
        eff_wr       = in_idle ? wr      : wr_q;
        eff_size     = in_idle ? size    : size_q;
        eff_addr     = in_idle ? address : addr_q;
        eff_wdata    = in_idle ? wdata   : wdata_q;
        idx          = eff_addr[DEPTH_LOG2+1:2];
        out_of_range = |eff_addr[31:DEPTH_LOG2+2];
`ifdef MEM_ALIGN_CHECK_EN
        misaligned   = ((eff_size == 2'b01) && eff_addr[0]) ||
                       (eff_size[1] && (eff_addr[1:0] != 2'b00));
`else
        misaligned   = 1'b0;
`endif
        fault        = out_of_range | misaligned;
        word         = mem[idx];
        word_sh      = word >> {eff_addr[1:0], 3'b000};
        case (eff_size)
            2'b00: begin
                rd_val  = {24'h0, word_sh[7:0]};
                wr_val  = {4{eff_wdata[7:0]}};
                wr_mask = 32'h0000_00FF << {eff_addr[1:0], 3'b000};
            end
            2'b01: begin
                rd_val  = {16'h0, (eff_addr[1] ? word[31:16] : word[15:0])};
                wr_val  = {2{eff_wdata[15:0]}};
                wr_mask = eff_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            end
            default: begin
                rd_val  = word;
                wr_val  = eff_wdata;
                wr_mask = 32'hFFFF_FFFF;
            end
        endcase
        mem_we = (state_q == S_RESP) && wr_q && !fault && !rst;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= (word & ~wr_mask) | (wr_val & wr_mask);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    size_d  = size;
                    addr_d  = address;
                    wdata_d = wdata;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_RESP);
        abort_d = ready_d && fault;
        rdata_d = (ready_d && !eff_wr && !fault) ? rd_val : 32'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            abort_q <= abort_d;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign abort = abort_q;
endmodule
